// File: rtl/ct_rtu_encode_96_seq_pkg.sv
// Shared constants and state encoding for the 96-entry RTU index serializer.
package ct_rtu_encode_96_seq_pkg;
    localparam int RTU_ENTRY_NUM = 96;
    localparam int RTU_IDX_W     = 7;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } rtu_enc_state_e;
endpackage

// File: rtl/ct_rtu_encode_96_seq_if.sv
// Load / index handshake bundle of the 96-entry serializer.
// master = producer/consumer side, slave = the serializer itself.
interface ct_rtu_encode_96_seq_if;
    import ct_rtu_encode_96_seq_pkg::*;

    logic                     x_load_vld;
    logic                     x_load_rdy;
    logic [RTU_ENTRY_NUM-1:0] x_load_vec;
    logic                     x_flush;
    logic                     x_idx_vld;
    logic                     x_idx_rdy;
    logic [RTU_IDX_W-1:0]     x_idx;
    logic                     x_idx_last;
    logic                     x_busy;
    logic                     x_done;

    modport master (
        output x_load_vld, x_load_vec, x_flush, x_idx_rdy,
        input  x_load_rdy, x_idx_vld, x_idx, x_idx_last, x_busy, x_done
    );

    modport slave (
        input  x_load_vld, x_load_vec, x_flush, x_idx_rdy,
        output x_load_rdy, x_idx_vld, x_idx, x_idx_last, x_busy, x_done
    );
endinterface

// File: rtl/ct_rtu_encode_96_seq_ffs.sv
// Combinational find-first-set over 96 bits: index of the lowest set bit
// plus a found flag (index is 0 when nothing is set).
module ct_rtu_ffs_96
    import ct_rtu_encode_96_seq_pkg::*;
(
    input  logic [RTU_ENTRY_NUM-1:0] vec,
    output logic [RTU_IDX_W-1:0]     idx,
    output logic                     found
);
    always_comb begin
        idx   = '0;
        found = 1'b0;
        // Scan downwards so the lowest set bit is the last one written.
        for (int i = RTU_ENTRY_NUM - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx   = RTU_IDX_W'(i);
                found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/ct_rtu_encode_96_seq.sv
// Serializes a 96-bit pending vector into one 7-bit index per handshake.
// Define CT_RTU_ENCODE_96_RR_EN for round-robin selection from a start pointer.
module ct_rtu_encode_96_seq
    import ct_rtu_encode_96_seq_pkg::*;
#(
    parameter int ENTRY_NUM = RTU_ENTRY_NUM,
    parameter int IDX_W     = RTU_IDX_W
) (
    input  logic                         forever_cpuclk,
    input  logic                         cpurst,
    ct_rtu_encode_96_seq_if.slave        bus
);
    rtu_enc_state_e       state_q, state_d;
    logic [ENTRY_NUM-1:0] pending_q, pending_d;
    logic                 done_q, done_d;

    logic [ENTRY_NUM-1:0] ffs_vec;
    logic [IDX_W-1:0]     ffs_idx;
    logic                 ffs_found;
    logic [IDX_W-1:0]     cur_idx;
    logic [IDX_W-1:0]     idx_out;
    logic                 is_last;
    logic                 idx_hs;

    ct_rtu_ffs_96 u_ffs (
        .vec   (ffs_vec),
        .idx   (ffs_idx),
        .found (ffs_found)
    );

    // Flush wins over the index handshake, so the pointer must not move then.
    assign idx_hs  = (state_q == ST_SCAN) & bus.x_idx_rdy & ~bus.x_flush;
    assign is_last = ((pending_q & (pending_q - ENTRY_NUM'(1))) == '0);
    assign idx_out = ffs_found ? cur_idx : '0;

`ifdef CT_RTU_ENCODE_96_RR_EN
    logic [IDX_W-1:0]       ptr_q, ptr_d;
    logic [2*ENTRY_NUM-1:0] dbl_vec;
    logic [IDX_W:0]         idx_sum;
    logic [IDX_W:0]         idx_wrap;

    // Rotate so bit 0 of the search vector is the entry at the pointer,
    // then add the pointer back modulo ENTRY_NUM.
    always_comb begin
        dbl_vec  = {pending_q, pending_q} >> ptr_q;
        ffs_vec  = dbl_vec[ENTRY_NUM-1:0];
        idx_sum  = {1'b0, ffs_idx} + {1'b0, ptr_q};
        idx_wrap = idx_sum - (IDX_W+1)'(ENTRY_NUM);
        cur_idx  = (idx_sum >= (IDX_W+1)'(ENTRY_NUM)) ? idx_wrap[IDX_W-1:0]
                                                       : idx_sum[IDX_W-1:0];
        ptr_d    = ptr_q;
        if (idx_hs) begin
            ptr_d = (idx_out == IDX_W'(ENTRY_NUM - 1)) ? '0 : idx_out + IDX_W'(1);
        end
    end

    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    assign ffs_vec = pending_q;
    assign cur_idx = ffs_idx;
`endif

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        done_d    = 1'b0;
        if (bus.x_flush) begin
            // In IDLE a flush is a no-op and also swallows any load.
            if (state_q == ST_SCAN) begin
                pending_d = '0;
                state_d   = ST_IDLE;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.x_load_vld) begin
                        pending_d = bus.x_load_vec;
                        if (bus.x_load_vec == '0) begin
                            done_d = 1'b1;
                        end else begin
                            state_d = ST_SCAN;
                        end
                    end
                end
                ST_SCAN: begin
                    if (bus.x_idx_rdy) begin
                        pending_d = pending_q & ~(ENTRY_NUM'(1) << idx_out);
                        if (is_last) begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            state_q   <= ST_IDLE;
            pending_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            done_q    <= done_d;
        end
    end

    assign bus.x_load_rdy = (state_q == ST_IDLE);
    assign bus.x_idx_vld  = (state_q == ST_SCAN);
    assign bus.x_busy     = (state_q == ST_SCAN);
    assign bus.x_idx_last = (state_q == ST_SCAN) & is_last;
    assign bus.x_idx      = idx_out;
    assign bus.x_done     = done_q;
endmodule

// File: tb/tb_ct_rtu_encode_96_seq.sv
// Self-checking bench for ct_rtu_encode_96_seq: directed scenarios plus
// randomized traffic against a set-of-entries reference model.
module tb_ct_rtu_encode_96_seq;
    import ct_rtu_encode_96_seq_pkg::*;

    logic clk = 1'b0;
    logic cpurst;
    always #5 clk = ~clk;

    ct_rtu_encode_96_seq_if bus();

    ct_rtu_encode_96_seq dut (
        .forever_cpuclk (clk),
        .cpurst         (cpurst),
        .bus            (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: which entries are still owed, whether a scan is open.
    bit m_pend[96];
    bit m_busy;
    bit m_done;
    int m_ptr;

    int emitted[$];
    int done_cnt;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < 96; i++) c += int'(m_pend[i]);
        return c;
    endfunction

    // Next entry to emit: first owed entry at or after the pointer (RR), else lowest.
    function automatic int m_first();
        for (int j = 0; j < 96; j++) begin
            int k;
`ifdef CT_RTU_ENCODE_96_RR_EN
            k = (m_ptr + j) % 96;
`else
            k = j;
`endif
            if (m_pend[k]) return k;
        end
        return 0;
    endfunction

    task automatic model_edge();
        bit nd = 1'b0;
        if (cpurst) begin
            for (int i = 0; i < 96; i++) m_pend[i] = 1'b0;
            m_busy = 1'b0;
            m_ptr  = 0;
        end else if (bus.x_flush) begin
            if (m_busy) begin
                for (int i = 0; i < 96; i++) m_pend[i] = 1'b0;
                m_busy = 1'b0;
            end
        end else if (!m_busy && bus.x_load_vld) begin
            for (int i = 0; i < 96; i++) m_pend[i] = bus.x_load_vec[i];
            if (m_count() == 0) nd = 1'b1;
            else m_busy = 1'b1;
        end else if (m_busy && bus.x_idx_rdy) begin
            int k = m_first();
            m_pend[k] = 1'b0;
            m_ptr = (k + 1) % 96;
            if (m_count() == 0) begin
                m_busy = 1'b0;
                nd = 1'b1;
            end
        end
        m_done = nd;
    endtask

    // One clock: log the accepted index, advance model, check all outputs.
    task automatic step();
        if (!cpurst && !bus.x_flush && bus.x_idx_vld === 1'b1 && bus.x_idx_rdy)
            emitted.push_back(int'(bus.x_idx));
        @(posedge clk);
        model_edge();
        #1;
        if (bus.x_done === 1'b1) done_cnt++;
        check_val("load_rdy", bus.x_load_rdy, 32'(!m_busy));
        check_val("idx_vld",  bus.x_idx_vld,  32'(m_busy));
        check_val("busy",     bus.x_busy,     32'(m_busy));
        check_val("done",     bus.x_done,     32'(m_done));
        if (m_busy) begin
            check_val("idx",      bus.x_idx,      32'(m_first()));
            check_val("idx_last", bus.x_idx_last, 32'(m_count() == 1));
        end else begin
            check_val("idx_last_idle", bus.x_idx_last, 32'd0);
        end
    endtask

    task automatic load(input logic [95:0] v);
        bus.x_load_vld = 1'b1;
        bus.x_load_vec = v;
        $display("load vec=%024h t=%0t", v, $time);
        step();
        bus.x_load_vld = 1'b0;
        bus.x_load_vec = '0;
    endtask

    function automatic logic [95:0] mk3(input int a, input int b, input int c);
        logic [95:0] v = '0;
        if (a >= 0) v[a] = 1'b1;
        if (b >= 0) v[b] = 1'b1;
        if (c >= 0) v[c] = 1'b1;
        return v;
    endfunction

    task automatic do_reset();
        cpurst = 1'b1;
        step();
        cpurst = 1'b0;
    endtask

    initial begin
        logic [95:0] rv;
        int mode;
        bus.x_load_vld = 1'b0;
        bus.x_load_vec = '0;
        bus.x_flush    = 1'b0;
        bus.x_idx_rdy  = 1'b0;
        cpurst         = 1'b1;
        done_cnt       = 0;
        step();
        step();
        check_val("rst_load_rdy", bus.x_load_rdy, 32'd1);
        check_val("rst_idx_vld",  bus.x_idx_vld,  32'd0);
        check_val("rst_idx",      bus.x_idx,      32'd0);
        check_val("rst_idx_last", bus.x_idx_last, 32'd0);
        check_val("rst_busy",     bus.x_busy,     32'd0);
        check_val("rst_done",     bus.x_done,     32'd0);
        cpurst = 1'b0;

        // {5,40,95} with consumer always ready
        emitted.delete(); done_cnt = 0;
        bus.x_idx_rdy = 1'b1;
        load(mk3(5, 40, 95));
        repeat (3) step();
        check_val("t1_done",    bus.x_done, 32'd1);
        check_val("t1_rdy",     bus.x_load_rdy, 32'd1);
        check_val("t1_n",       emitted.size(), 32'd3);
        check_val("t1_i0",      emitted[0], 32'd5);
        check_val("t1_i1",      emitted[1], 32'd40);
        check_val("t1_i2",      emitted[2], 32'd95);
        check_val("t1_donecnt", done_cnt, 32'd1);

        // {7,8} with backpressure for three cycles
        emitted.delete(); done_cnt = 0;
        bus.x_idx_rdy = 1'b0;
        load(mk3(7, 8, -1));
        check_val("t2_hold0", bus.x_idx, 32'd7);
        step();
        check_val("t2_hold1", bus.x_idx, 32'd7);
        step();
        check_val("t2_hold2", bus.x_idx, 32'd7);
        bus.x_idx_rdy = 1'b1;
        repeat (3) step();
        check_val("t2_n",       emitted.size(), 32'd2);
        check_val("t2_i0",      emitted[0], 32'd7);
        check_val("t2_i1",      emitted[1], 32'd8);
        check_val("t2_donecnt", done_cnt, 32'd1);

        // zero vector
        emitted.delete(); done_cnt = 0;
        load('0);
        check_val("t3_done", bus.x_done, 32'd1);
        check_val("t3_busy", bus.x_busy, 32'd0);
        step(); step();
        check_val("t3_n",       emitted.size(), 32'd0);
        check_val("t3_donecnt", done_cnt, 32'd1);

        // flush while index 2 is shown
        done_cnt = 0;
        load(mk3(1, 2, 3));
        step();
        check_val("t4_idx2", bus.x_idx, 32'd2);
        bus.x_flush = 1'b1;
        step();
        bus.x_flush = 1'b0;
        check_val("t4_vld",  bus.x_idx_vld, 32'd0);
        check_val("t4_rdy",  bus.x_load_rdy, 32'd1);
        step();
        check_val("t4_donecnt", done_cnt, 32'd0);

        // reset mid-scan
        load(mk3(1, 2, 3));
        step();
        do_reset();
        check_val("t4r_vld", bus.x_idx_vld, 32'd0);
        check_val("t4r_rdy", bus.x_load_rdy, 32'd1);
        step();
        check_val("t4r_donecnt", done_cnt, 32'd0);

        // all ones
        emitted.delete(); done_cnt = 0;
        load({96{1'b1}});
        repeat (96) step();
        check_val("t5_done", bus.x_done, 32'd1);
        check_val("t5_n",    emitted.size(), 32'd96);
        for (int i = 0; i < 96; i++) check_val("t5_order", emitted[i], 32'(i));
        check_val("t5_donecnt", done_cnt, 32'd1);

        // selection order after a previous scan
        do_reset();
        load(mk3(10, 20, -1));
        repeat (3) step();
        emitted.delete();
        load(mk3(5, 30, -1));
        repeat (3) step();
        check_val("t6_n", emitted.size(), 32'd2);
`ifdef CT_RTU_ENCODE_96_RR_EN
        check_val("t6_i0", emitted[0], 32'd30);
        check_val("t6_i1", emitted[1], 32'd5);
`else
        check_val("t6_i0", emitted[0], 32'd5);
        check_val("t6_i1", emitted[1], 32'd30);
`endif

        // randomized traffic
        for (int c = 0; c < 1500; c++) begin
            mode = int'($urandom_range(3));
            case (mode)
                0: rv = '0;
                1: begin rv = '0; rv[$urandom_range(95)] = 1'b1; end
                2: rv = {$urandom, $urandom, $urandom} & {$urandom, $urandom, $urandom}
                        & {$urandom, $urandom, $urandom};
                default: rv = {$urandom, $urandom, $urandom};
            endcase
            bus.x_load_vec = rv;
            bus.x_load_vld = 1'($urandom_range(1));
            bus.x_idx_rdy  = ($urandom_range(3) != 0);
            bus.x_flush    = ($urandom_range(30) == 0);
            cpurst         = ($urandom_range(200) == 0);
            if (bus.x_load_vld && !m_busy && !bus.x_flush && !cpurst)
                $display("load vec=%024h t=%0t", rv, $time);
            step();
        end
        cpurst = 1'b0;
        bus.x_flush = 1'b0;
        bus.x_load_vld = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ct_rtu_encode_96_seq.md
Name: ct_rtu_encode_96_seq

Overview:
- Sequential one-hot/multi-hot to binary index serializer for 96-entry RTU structures; the inverse of the 7-bit-to-96-bit one-hot expander.
- Accepts a 96-bit pending vector and emits the 7-bit index of each set bit, one per valid/ready handshake, lowest index first.
- Used where RTU must walk a per-entry bitmap one entry per cycle, e.g. ROB/PST entry release or commit walk.

Parameters:
- ENTRY_NUM, 96, number of vector bits; only 96 is supported.
- IDX_W, 7, index width; must equal clog2(ENTRY_NUM).

Ports:
- forever_cpuclk  in  1  clock.
- cpurst  in  1  reset; synchronous, active-high.
- x_load_vld  in  1  load request.
- x_load_rdy  out  1  block idle, able to accept a load.
- x_load_vec  in  96  vector to serialize.
- x_flush  in  1  abort the current scan.
- x_idx_vld  out  1  x_idx is valid.
- x_idx_rdy  in  1  consumer accepts x_idx.
- x_idx  out  7  binary index of the current set bit.
- x_idx_last  out  1  x_idx is the final pending bit.
- x_busy  out  1  scan in progress.
- x_done  out  1  one-cycle pulse when a scan completes.

Behaviour:
- Single clock; reset is synchronous and active-high. All state updates occur on the rising edge of forever_cpuclk.
- Reset (cpurst=1 at an edge) clears the pending register to 0, sets state to IDLE and clears x_done. After reset:
  - x_load_rdy=1
  - x_idx_vld=0
  - x_idx=0
  - x_idx_last=0
  - x_busy=0
  - x_done=0
- Reset mid-scan discards all pending bits; no x_done pulse is produced.
- State machine has two states, IDLE and SCAN.
- IDLE:
  - x_load_rdy=1.
  - A load handshake (x_load_vld & x_load_rdy) captures x_load_vec into the pending register.
  - Nonzero vector: go to SCAN next cycle.
  - Zero vector: stay IDLE and pulse x_done next cycle.
- SCAN:
  - x_load_rdy=0, x_busy=1, x_idx_vld=1.
  - x_idx = lowest set pending bit.
  - x_idx_last=1 when exactly one bit is pending, i.e. pending & (pending-1) == 0.
- Index handshake (x_idx_vld & x_idx_rdy) clears pending[x_idx]. If that index was last, go to IDLE and pulse x_done next cycle.
- Latency and throughput:
  - Load at edge N gives the first x_idx_vld in cycle N+1.
  - One index per cycle when x_idx_rdy is held high.
  - K set bits take K cycles.
- Backpressure: while x_idx_rdy=0, x_idx and x_idx_last are held stable.
- x_idx, x_idx_vld, x_idx_last, x_busy and x_load_rdy depend only on registered state. There is no combinational input-to-output path.
- Flush:
  - x_flush at an edge clears pending and returns to IDLE with no x_done pulse.
  - Flush has priority over a same-cycle index handshake and over a load.
  - A flush in IDLE is a no-op, and any same-cycle load is dropped.
- x_done is registered, high for exactly one cycle. x_load_rdy is already high in the x_done cycle, so back-to-back loads are allowed.
- Index range is always 0..95; no out-of-range values are produced.

Optional Feature:
- Macro: CT_RTU_ENCODE_96_RR_EN.
- Defined:
  - A 7-bit start pointer, reset to 0, is set to (emitted index + 1) mod 96 on every index handshake; 95 wraps to 0.
  - Selection order is the first set bit at or after the pointer, wrapping.
  - The pointer persists across loads and is cleared only by reset; flush does not clear it.
- Undefined: fixed priority from bit 0 and no pointer register.

Decomposition:
- Shared package holds:
  - RTU_ENTRY_NUM=96 and RTU_IDX_W=7.
  - The state encoding (IDLE=1'b0, SCAN=1'b1).
- Sub-module ct_rtu_ffs_96: combinational find-first-set over 96 bits, outputting a 7-bit index and a found flag. It is instantiated once. In RR mode it is fed the vector rotated by the pointer, and the pointer is added back mod 96.

Test Plan:
- Load bits {5,40,95} at edge N with x_idx_rdy=1 -> indices 5, 40, 95 in cycles N+1..N+3, x_idx_last only with 95, x_done in cycle N+4, x_load_rdy=1 in cycle N+4.
- Load {7,8} with x_idx_rdy low for 3 cycles -> x_idx=7 held stable 3 cycles, then 7 then 8 on release, x_done once.
- Load vector 0 -> x_idx_vld never asserts, x_done pulses in cycle N+1, x_busy stays 0.
- Load {1,2,3}, x_flush in the cycle index 2 is shown -> x_idx_vld=0 next cycle, no x_done, x_load_rdy=1; cpurst mid-scan gives the same result.
- Load all-ones -> indices 0..95 in 96 consecutive cycles, x_idx_last only at 95, a single x_done.
- RR build: serialize {10,20}, then load {5,30} -> order 30, 5. Non-RR build: same stimulus -> order 5, 30.
